// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - scanned, debounced matrix keypad front-end
//
// Drives one keypad column low at a time, samples the synchronized row lines
// once per column dwell, debounces press and release, and reports key events.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   row_n        keypad rows, low = closed key on the driven column (async)
//   col_n        column drive, exactly one bit low
//   key_code     row*COLS + col of the last accepted key
//   key_valid    one-cycle pulse on accepted press
//   key_release  one-cycle pulse on accepted release
//   key_held     high while an accepted key has not been released
//   debug        current state encoding

module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4,
    localparam int KW      = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_release,
    output logic            key_held,
    output logic [1:0]      debug
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SCAN_DIV);

    localparam logic [1:0] S_SCAN    = 2'b00;
    localparam logic [1:0] S_CONFIRM = 2'b01;
    localparam logic [1:0] S_HELD    = 2'b10;

    logic [ROWS-1:0] r_sync1;
    logic [ROWS-1:0] r_sync2;
    logic [DW-1:0]   r_div_cnt;
    logic [CW-1:0]   r_col_idx;
    logic [COLS-1:0] r_col_n;
    logic [1:0]      r_state;
    logic [RW-1:0]   r_cand_row;
    logic [CW-1:0]   r_cand_col;
    logic [3:0]      r_stable_cnt;
    logic [3:0]      r_rel_cnt;
    logic [KW-1:0]   r_key_code;
    logic            r_key_valid;
    logic            r_key_release;
    logic            r_key_held;

    logic            w_sample;
    logic            w_any_low;
    logic [RW-1:0]   w_low_row;
    logic            w_cand_high;
    logic [CW-1:0]   w_col_next;
    logic [COLS-1:0] w_col_n_next;

    assign w_sample     = (r_div_cnt == DW'(SCAN_DIV - 1));
    assign w_any_low    = ~&r_sync2;
    assign w_cand_high  = r_sync2[r_cand_row];
    assign w_col_next   = (r_col_idx == CW'(COLS - 1)) ? '0 : r_col_idx + CW'(1);
    assign w_col_n_next = ~(COLS'(1) << w_col_next);

    // Lowest-indexed low row wins when several keys share the driven column.
    always_comb begin
        w_low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r_sync2[i]) begin
                w_low_row = RW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1       <= '1;
            r_sync2       <= '1;
            r_div_cnt     <= '0;
            r_col_idx     <= '0;
            r_col_n       <= ~(COLS'(1));
            r_state       <= S_SCAN;
            r_cand_row    <= '0;
            r_cand_col    <= '0;
            r_stable_cnt  <= '0;
            r_rel_cnt     <= '0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_held    <= 1'b0;
        end else begin
            r_sync1       <= row_n;
            r_sync2       <= r_sync1;
            r_div_cnt     <= w_sample ? '0 : r_div_cnt + DW'(1);
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;

            case (r_state)
                S_SCAN: begin
                    if (w_sample) begin
                        if (w_any_low) begin
                            // Column is left in place so the candidate keeps being driven.
                            r_cand_row   <= w_low_row;
                            r_cand_col   <= r_col_idx;
                            r_stable_cnt <= 4'd1;
                            r_state      <= S_CONFIRM;
                        end else begin
                            r_col_idx <= w_col_next;
                            r_col_n   <= w_col_n_next;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (w_sample) begin
                        if (!w_cand_high) begin
                            if (r_stable_cnt == 4'(DEBOUNCE - 1)) begin
                                r_key_code  <= KW'(r_cand_row) * KW'(COLS) + KW'(r_cand_col);
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_rel_cnt   <= '0;
                                r_state     <= S_HELD;
                            end else begin
                                r_stable_cnt <= r_stable_cnt + 4'd1;
                            end
                        end else begin
                            r_state   <= S_SCAN;
                            r_col_idx <= w_col_next;
                            r_col_n   <= w_col_n_next;
                        end
                    end
                end
                S_HELD: begin
                    if (w_sample) begin
                        if (w_cand_high) begin
                            if (r_rel_cnt == 4'(DEBOUNCE - 1)) begin
                                r_key_release <= 1'b1;
                                r_key_held    <= 1'b0;
                                r_rel_cnt     <= '0;
                                r_state       <= S_SCAN;
                                r_col_idx     <= w_col_next;
                                r_col_n       <= w_col_n_next;
                            end else begin
                                r_rel_cnt <= r_rel_cnt + 4'd1;
                            end
                        end else begin
                            // Any bounce back to closed restarts the release run.
                            r_rel_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state    <= S_SCAN;
                    r_col_idx  <= '0;
                    r_col_n    <= ~(COLS'(1));
                    r_key_held <= 1'b0;
                end
            endcase
        end
    end

    assign col_n       = r_col_n;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_release = r_key_release;
    assign key_held    = r_key_held;
    assign debug       = r_state;

endmodule
